cz80_alu16_seq: RTL and testbench
=================================

# cz80_alu16_seq

Two-pass sequencer that performs Z80 16-bit arithmetic (ADD/ADC/SBC HL,rr-class) on the 8-bit `cz80_alu`. It accepts one 16-bit request over a valid/ready handshake. It drives the ALU with the low byte, then the high byte, chaining flags between the passes, and returns a 16-bit result with final flags. It sits between the cz80 microcode sequencer and the shared `cz80_alu` instance; while busy it owns the ALU input buses.

## Interface
Parameters: none.

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  high only in IDLE; request accepted on `req_valid & req_ready`
- req_op  in  2  00 ADD16, 01 ADC16, 10 SBC16, 11 CP16 (see Configuration)
- req_a  in  16  first operand (HL side)
- req_b  in  16  second operand (rr side)
- req_f  in  8  incoming F register (Z80 layout: S7 Z6 H4 PV2 N1 C0)
- alu_op  out  4  to `cz80_alu.alu_op`
- alu_busa, alu_busb  out  8 each  to ALU buses
- alu_f_in  out  8  to ALU flag input
- alu_arith16, alu_z16  out  1 each  to ALU
- alu_cpi  out  1  constant 0
- alu_ir  out  6  constant 0
- alu_iset  out  2  constant 0
- alu_q  in  8  ALU result (combinational from the alu_* outputs)
- alu_f_out  in  8  ALU flag result
- res_valid  out  1  result available; held until taken
- res_ready  in  1  consumer accepts result on `res_valid & res_ready`
- res_q  out  16  16-bit result
- res_f  out  8  final flags

## Operation
- States: IDLE, LO, HI, DONE.
- IDLE → LO on accept. Latch req_a, req_b, req_op, and req_f into internal registers.
- LO:
  - Drive alu_busa = a[7:0], alu_busb = b[7:0], alu_f_in = latched req_f.
  - alu_op: 0 (ADD) for ADD16/ADC16; 2 (SUB) for SBC16/CP16. The low pass of ADC16/SBC16 uses ADC (1) or SBC (3) so that the incoming C is consumed.
  - At end of cycle, capture alu_q → res_q[7:0] and alu_f_out → lo_f. → HI.
- HI:
  - Drive alu_busa = a[15:8], alu_busb = b[15:8], alu_f_in = lo_f.
  - alu_op: 1 (ADC) for ADD16/ADC16; 3 (SBC) for SBC16/CP16.
  - Capture alu_q → res_q[15:8] and alu_f_out → res_f. → DONE.
- Pass control bits:
  - ADD16: alu_arith16 = 1 in both passes, alu_z16 = 0. S, Z, PV are preserved from req_f.
  - ADC16/SBC16/CP16: alu_arith16 = 0. alu_z16 = 0 in LO and 1 in HI, so Z reflects all 16 bits.
- DONE: res_valid = 1; res_q and res_f are stable. On res_ready → IDLE.
- In IDLE and DONE, the alu_* outputs are driven to zero.
- Simultaneous `res_valid & res_ready` and `req_valid`: the new request is not accepted that cycle, because req_ready asserts only in IDLE.
- Reset in any state → IDLE on the next edge. An in-flight request is dropped and no result is emitted.

## Timing
- Every output is registered or state-decoded; there is no combinational path from req_* or res_ready to any output.
- Reset values:
  - req_ready = 1 (IDLE)
  - res_valid = 0, res_q = 0x0000, res_f = 0x00
  - all alu_* = 0
- Accept at edge N:
  - LO is driven in cycle N+1.
  - HI is driven in cycle N+2.
  - res_valid is high from edge N+3.
  - Minimum latency is 3 cycles; throughput is one request per 4 cycles.
- res_valid holds, with res_q/res_f unchanged, for any number of cycles while res_ready = 0.
- alu_q and alu_f_out are sampled only at the ends of LO and HI.

## Configuration
- `CZ80_ALU16_SEQ_CP16_EN` defined:
  - req_op = 11 performs a 16-bit compare, i.e. SBC16 flag behaviour with incoming C forced to 0.
  - res_f carries the compare flags and res_q = latched req_a (the difference is discarded).
- Not defined:
  - req_op = 11 is still accepted and completes with the same 3-cycle latency, but no ALU pass is issued.
  - alu_* stays 0; res_q = req_a and res_f = req_f, unchanged.

## Test plan
- ADD16, a = 0xFFFF, b = 0x0001, req_f = 0x44 (Z, PV set) → res_q = 0x0000; res_f C = 1, Z = 1, PV = 1 (preserved), N = 0; res_valid at edge N+3.
- ADC16, a = 0xFFFF, b = 0x0000, req_f C = 1 → res_q = 0x0000, Z = 1, C = 1, S = 0.
- SBC16, a = 0x0000, b = 0x0001, req_f C = 0 → res_q = 0xFFFF, S = 1, Z = 0, N = 1, C = 1. Also: SBC16 a = 0x0100, b = 0x0001, C = 0 → res_q = 0x00FF, Z = 0, proving Z spans both bytes.
- Backpressure: hold res_ready = 0 for 5 cycles after res_valid → res_valid stays 1, res_q/res_f stable, req_ready = 0, req_valid ignored; release → IDLE next edge.
- Reset asserted during HI → next edge req_ready = 1, res_valid = 0, alu_* = 0; no result is ever presented for the dropped request.
- CP16 with a = 0x1234, b = 0x1234: with the macro → res_q = 0x1234, Z = 1, N = 1, C = 0. Without the macro → res_q = 0x1234, res_f = req_f, alu_op stays 0 throughout.

Source files
------------

// File: rtl/cz80_alu16_seq.sv
// cz80_alu16_seq: two-pass 16-bit ADD/ADC/SBC sequencer over the 8-bit cz80_alu; CZ80_ALU16_SEQ_CP16_EN enables CP16.
module cz80_alu16_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  input  logic [7:0]  req_f,
  output logic [3:0]  alu_op,
  output logic [7:0]  alu_busa,
  output logic [7:0]  alu_busb,
  output logic [7:0]  alu_f_in,
  output logic        alu_arith16,
  output logic        alu_z16,
  output logic        alu_cpi,
  output logic [5:0]  alu_ir,
  output logic [1:0]  alu_iset,
  input  logic [7:0]  alu_q,
  input  logic [7:0]  alu_f_out,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [15:0] res_q,
  output logic [7:0]  res_f
);
  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;
  state_t state, state_nx;
  logic [15:0] a, b;
  logic [1:0] op;
  logic [7:0] f, lo_f;
  logic cp, pass, drive, hi;
  assign cp = op == 2'b11;
`ifdef CZ80_ALU16_SEQ_CP16_EN
  assign pass = 1'b1;
`else
  assign pass = !cp;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb
    state_nx = state == IDLE ? (req_valid ? LO : IDLE) :
               state == LO   ? HI :
               state == HI   ? DONE :
               (res_ready ? IDLE : DONE);
  // Low pass of ADC16/SBC16 must consume incoming C, so bit 0 is set there too
  always_comb begin
    hi          = state == HI;
    drive       = pass && (state == LO || hi);
    alu_op      = drive ? {2'b00, op[1], hi | (op[0] ^ op[1])} : 4'd0;
    alu_busa    = drive ? (hi ? a[15:8] : a[7:0]) : 8'd0;
    alu_busb    = drive ? (hi ? b[15:8] : b[7:0]) : 8'd0;
    alu_f_in    = drive ? (hi ? lo_f : f) : 8'd0;
    alu_arith16 = drive && op == 2'b00;
    alu_z16     = drive && hi && op != 2'b00;
    alu_cpi     = 1'b0;
    alu_ir      = 6'd0;
    alu_iset    = 2'd0;
    req_ready   = state == IDLE;
    res_valid   = state == DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a     <= 16'd0;
      b     <= 16'd0;
      op    <= 2'd0;
      f     <= 8'd0;
      lo_f  <= 8'd0;
      res_q <= 16'd0;
      res_f <= 8'd0;
    end else if (state == IDLE && req_valid) begin
      a  <= req_a;
      b  <= req_b;
      op <= req_op;
      f  <= req_f;
    end else if (state == LO) begin
      res_q[7:0] <= (pass && !cp) ? alu_q : a[7:0];
      lo_f       <= alu_f_out;
    end else if (state == HI) begin
      res_q[15:8] <= (pass && !cp) ? alu_q : a[15:8];
      res_f       <= pass ? alu_f_out : f;
    end
  end
endmodule

// File: tb/tb_cz80_alu16_seq.sv
// tb_cz80_alu16_seq: randomized scoreboard bench; a byte-level ALU stand-in answers the DUT, a 16-bit model predicts results.
module tb_cz80_alu16_seq;
`ifdef CZ80_ALU16_SEQ_CP16_EN
  localparam bit CP_EN = 1'b1;
`else
  localparam bit CP_EN = 1'b0;
`endif
  logic clk = 0, reset = 1, req_valid = 0, res_ready = 0;
  logic [1:0] req_op = 0;
  logic [15:0] req_a = 0, req_b = 0;
  logic [7:0] req_f = 0;
  logic req_ready, alu_arith16, alu_z16, alu_cpi, res_valid;
  logic [3:0] alu_op;
  logic [7:0] alu_busa, alu_busb, alu_f_in, alu_q, alu_f_out, res_f;
  logic [5:0] alu_ir;
  logic [1:0] alu_iset;
  logic [15:0] res_q;
  int checks = 0, failures = 0, cyc = 0;
  bit bp = 0, seen = 0;
  typedef struct {logic [15:0] q; logic [7:0] f; int acc;} exp_t;
  exp_t sb[$];

  cz80_alu16_seq dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_a(req_a), .req_b(req_b), .req_f(req_f), .alu_op(alu_op), .alu_busa(alu_busa),
    .alu_busb(alu_busb), .alu_f_in(alu_f_in), .alu_arith16(alu_arith16), .alu_z16(alu_z16),
    .alu_cpi(alu_cpi), .alu_ir(alu_ir), .alu_iset(alu_iset), .alu_q(alu_q),
    .alu_f_out(alu_f_out), .res_valid(res_valid), .res_ready(res_ready), .res_q(res_q), .res_f(res_f)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared 8-bit ALU (ops 0..3 only)
  logic [8:0] m_r;
  logic [4:0] m_h;
  logic m_c, m_v;
  always_comb begin
    m_c = alu_op[0] & alu_f_in[0];
    m_r = alu_op[1] ? {1'b0, alu_busa} - {1'b0, alu_busb} - {8'd0, m_c}
                    : {1'b0, alu_busa} + {1'b0, alu_busb} + {8'd0, m_c};
    m_h = alu_op[1] ? {1'b0, alu_busa[3:0]} - {1'b0, alu_busb[3:0]} - {4'd0, m_c}
                    : {1'b0, alu_busa[3:0]} + {1'b0, alu_busb[3:0]} + {4'd0, m_c};
    m_v = alu_op[1] ? (alu_busa[7] != alu_busb[7]) && (m_r[7] != alu_busa[7])
                    : (alu_busa[7] == alu_busb[7]) && (m_r[7] != alu_busa[7]);
    alu_q = m_r[7:0];
    alu_f_out = {m_r[7], alu_z16 ? (alu_f_in[6] & (m_r[7:0] == 8'd0)) : (m_r[7:0] == 8'd0),
                 m_r[5], m_h[4], m_r[3], m_v, alu_op[1], m_r[8]};
    if (alu_arith16) {alu_f_out[7], alu_f_out[6], alu_f_out[2]} = {alu_f_in[7], alu_f_in[6], alu_f_in[2]};
  end

  function automatic exp_t ref16(logic [1:0] op, logic [15:0] a, logic [15:0] b, logic [7:0] f);
    exp_t e;
    logic [16:0] r;
    logic [12:0] h;
    logic c, v;
    c = (op == 2'd1 || op == 2'd2) ? f[0] : 1'b0;
    if (op[1]) begin
      r = {1'b0, a} - {1'b0, b} - {16'd0, c};
      h = {1'b0, a[11:0]} - {1'b0, b[11:0]} - {12'd0, c};
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end else begin
      r = {1'b0, a} + {1'b0, b} + {16'd0, c};
      h = {1'b0, a[11:0]} + {1'b0, b[11:0]} + {12'd0, c};
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end
    e.f = {r[15], r[15:0] == 16'd0, r[13], h[12], r[11], v, op[1], r[16]};
    if (op == 2'd0) {e.f[7], e.f[6], e.f[2]} = {f[7], f[6], f[2]};
    e.q = op == 2'd3 ? a : r[15:0];
    if (op == 2'd3 && !CP_EN) e.f = f;
    e.acc = 0;
    return e;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (1) begin
      @(negedge clk);
      if (req_ready) break;
      if (++n > 50) begin
        chk("req_ready_timeout", 0, 1);
        break;
      end
    end
  endtask

  // Issue one request; called just after a rising edge, returns just after the edge entering DONE
  task automatic issue(logic [1:0] op, logic [15:0] a, logic [15:0] b, logic [7:0] f);
    exp_t e;
    logic [3:0] lo_op, hi_op;
    lo_op = op == 2'd0 ? 4'd0 : op == 2'd1 ? 4'd1 : op == 2'd2 ? 4'd3 : (CP_EN ? 4'd2 : 4'd0);
    hi_op = op == 2'd0 ? 4'd1 : op == 2'd1 ? 4'd1 : op == 2'd2 ? 4'd3 : (CP_EN ? 4'd3 : 4'd0);
    req_op = op; req_a = a; req_b = b; req_f = f; req_valid = 1;
    wait_ready();
    e = ref16(op, a, b, f);
    e.acc = cyc;
    sb.push_back(e);
    @(posedge clk); #1 req_valid = 0; req_a = $urandom; req_b = $urandom; req_f = $urandom;
    @(negedge clk);
    chk("lo_alu_op", alu_op, lo_op);
    chk("lo_busa", alu_busa, (op == 2'd3 && !CP_EN) ? 8'd0 : a[7:0]);
    @(negedge clk);
    chk("hi_alu_op", alu_op, hi_op);
    chk("hi_busb", alu_busb, (op == 2'd3 && !CP_EN) ? 8'd0 : b[15:8]);
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 || !req_ready) begin
      @(negedge clk);
      if (++n > 100) begin
        chk("drain_timeout", sb.size(), 0);
        break;
      end
    end
    @(posedge clk); #1;
  endtask

  // Monitor: pops the scoreboard on every result handshake
  initial forever begin
    @(negedge clk);
    if (!reset && res_valid) begin
      if (sb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        if (!seen) chk("latency", cyc - sb[0].acc, 3);
        seen = 1;
        if (res_ready) begin
          chk("res_q", res_q, sb[0].q);
          chk("res_f", res_f, sb[0].f);
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (!bp) res_ready = $urandom_range(0, 3) != 0;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pick [5];
    int n;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_q", res_q, 0);
    chk("rst_res_f", res_f, 0);
    chk("rst_alu", {alu_op, alu_busa, alu_busb, alu_f_in}, 0);
    chk("rst_alu_ctl", {alu_arith16, alu_z16, alu_cpi, alu_ir, alu_iset}, 0);
    @(posedge clk); #1;
    issue(2'd0, 16'hFFFF, 16'h0001, 8'h44);
    issue(2'd1, 16'hFFFF, 16'h0000, 8'h01);
    issue(2'd2, 16'h0000, 16'h0001, 8'h00);
    issue(2'd2, 16'h0100, 16'h0001, 8'h00);
    issue(2'd3, 16'h1234, 16'h1234, 8'h81);
    wait_drain();
    // Backpressure: result must hold while res_ready stays low, and requests are ignored
    bp = 1; res_ready = 0;
    issue(2'd1, 16'h7FFF, 16'h0001, 8'h00);
    n = 0;
    while (!res_valid && n < 10) begin @(negedge clk); n++; end
    chk("bp_valid_seen", res_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1 req_valid = 1; req_op = 2'd0;
      @(negedge clk);
      chk("bp_valid_hold", res_valid, 1);
      chk("bp_req_ready", req_ready, 0);
      if (sb.size() != 0) chk("bp_q_stable", {res_q, res_f}, {sb[0].q, sb[0].f});
    end
    @(posedge clk); #1 req_valid = 0; res_ready = 1;
    @(posedge clk); #1;
    chk("bp_release_idle", {req_ready, res_valid}, 2'b10);
    bp = 0;
    wait_drain();
    // Reset during HI drops the request
    req_op = 2'd2; req_a = 16'h5555; req_b = 16'h1111; req_f = 8'h01; req_valid = 1;
    wait_ready();
    @(posedge clk); #1 req_valid = 0;
    @(posedge clk); #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk("rst_hi_req_ready", req_ready, 1);
    chk("rst_hi_res_valid", res_valid, 0);
    chk("rst_hi_alu", {alu_op, alu_busa, alu_busb, alu_f_in, alu_arith16, alu_z16}, 0);
    repeat (6) @(posedge clk);
    #1;
    pick[0] = 16'h0000; pick[1] = 16'hFFFF; pick[2] = 16'h8000; pick[3] = 16'h7FFF;
    for (int i = 0; i < 40; i++) begin
      pick[4] = 16'($urandom);
      issue(2'($urandom), pick[$urandom_range(0, 4)], pick[$urandom_range(0, 4)], 8'($urandom));
    end
    wait_drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
